if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: streams 16-bit instructions into the IF/ID slot,
// absorbs downstream holds with a one-entry skid buffer and handles redirects.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        IF_ID_Hold,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_target_i,
  output logic        IF_ID_Flush,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [15:0] imem_rdata_i,
  output logic [15:0] PC_o,
  output logic [15:0] Instr_o,
  output logic        valid_o
);

  localparam logic [15:0] STEP_C = 16'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    STALL = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic        req_q, req_d;
  logic        adv_s;

  assign adv_s       = ~IF_ID_Hold | ~valid_q;
  assign IF_ID_Flush = branch_taken_i;
  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign PC_o        = pc_q;
  assign Instr_o     = instr_q;
  assign valid_o     = valid_q;

  // Next-state and datapath selection; a redirect overrides every other event.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    addr_d       = addr_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_valid_d = skid_valid_q;

    if (branch_taken_i) begin
      fetch_pc_d   = branch_target_i;
      valid_d      = 1'b0;
      instr_d      = 16'h0000;
      skid_valid_d = 1'b0;
      case (state_q)
        FETCH, DRAIN: begin
          // An outstanding request must complete before the new target is issued.
          if (imem_ready_i) begin
            addr_d  = branch_target_i;
            state_d = FETCH;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          addr_d  = branch_target_i;
          state_d = FETCH;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          addr_d  = fetch_pc_q;
          state_d = FETCH;
        end
        FETCH: begin
          if (imem_ready_i) begin
            fetch_pc_d = fetch_pc_q + STEP_C;
            if (adv_s) begin
              pc_d    = addr_q;
              instr_d = imem_rdata_i;
              valid_d = 1'b1;
              addr_d  = addr_q + STEP_C;
            end else begin
              skid_pc_d    = addr_q;
              skid_instr_d = imem_rdata_i;
              skid_valid_d = 1'b1;
              state_d      = STALL;
            end
          end else begin
            if (adv_s) begin
              valid_d = 1'b0;
              instr_d = 16'h0000;
            end else begin
              valid_d = valid_q;
            end
          end
        end
        DRAIN: begin
          if (imem_ready_i) begin
            addr_d  = fetch_pc_q;
            state_d = FETCH;
          end else begin
            state_d = DRAIN;
          end
        end
        STALL: begin
          if (adv_s) begin
            pc_d         = skid_pc_q;
            instr_d      = skid_instr_q;
            valid_d      = skid_valid_q;
            skid_valid_d = 1'b0;
            addr_d       = fetch_pc_q;
            state_d      = FETCH;
          end else begin
            state_d = STALL;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    req_d = (state_d == FETCH) || (state_d == DRAIN);
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      addr_q       <= RESET_PC;
      pc_q         <= 16'h0000;
      instr_q      <= 16'h0000;
      valid_q      <= 1'b0;
      skid_pc_q    <= 16'h0000;
      skid_instr_q <= 16'h0000;
      skid_valid_q <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      addr_q       <= addr_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_valid_q <= skid_valid_d;
      req_q        <= req_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed scenarios push expected slot
// contents; a negedge monitor pops and compares every consumed instruction.
module tb_if_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        IF_ID_Hold;
  logic        branch_taken_i;
  logic [15:0] branch_target_i;
  logic        IF_ID_Flush;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ready_i;
  logic [15:0] imem_rdata_i;
  logic [15:0] PC_o;
  logic [15:0] Instr_o;
  logic        valid_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  if_fetch_unit dut (
    .clk_i(clk_i), .rst_n(rst_n), .IF_ID_Hold(IF_ID_Hold),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .IF_ID_Flush(IF_ID_Flush), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
    .PC_o(PC_o), .Instr_o(Instr_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory contents: each word holds its own address plus 16'h1000.
  assign imem_rdata_i = imem_addr_o + 16'h1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // A slot is consumed when it is valid, not held and not flushed.
  always @(negedge clk_i) begin
    if (rst_n && valid_o && !IF_ID_Hold && !branch_taken_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL slot_unexpected: got PC_o=%h Instr_o=%h expected none", PC_o, Instr_o);
      end else begin
        chk("slot", {PC_o, Instr_o}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; IF_ID_Hold = 1'b0; branch_taken_i = 1'b0;
    branch_target_i = 16'h0000; imem_ready_i = 1'b1;
    step(2);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_req",   {31'd0, imem_req_o}, 32'd0);
    chk("rst_pc",    {16'd0, PC_o}, 32'h0000_0000);
    chk("rst_instr", {16'd0, Instr_o}, 32'h0000_0000);
    chk("rst_addr",  {16'd0, imem_addr_o}, 32'h0000_0000);

    // Back-to-back streaming, then a three-cycle hold at PC 4.
    rst_n = 1'b1;
    chk("idle_req", {31'd0, imem_req_o}, 32'd0);
    push(16'h0000, 16'h1000); push(16'h0002, 16'h1002); push(16'h0004, 16'h1004);
    step(1);
    chk("first_req",  {31'd0, imem_req_o}, 32'd1);
    chk("first_addr", {16'd0, imem_addr_o}, 32'h0000_0000);
    step(3);
    IF_ID_Hold = 1'b1;
    step(1);
    chk("stall_req", {31'd0, imem_req_o}, 32'd0);
    chk("stall_pc",  {PC_o, Instr_o}, 32'h0004_1004);
    step(2);
    chk("stall_hold_pc", {PC_o, Instr_o}, 32'h0004_1004);
    chk("stall_hold_req", {31'd0, imem_req_o}, 32'd0);
    IF_ID_Hold = 1'b0;
    push(16'h0006, 16'h1006); push(16'h0008, 16'h1008);
    step(1);
    chk("resume_addr", {16'd0, imem_addr_o}, 32'h0000_0008);
    chk("resume_req",  {31'd0, imem_req_o}, 32'd1);
    step(1);
    imem_ready_i = 1'b0;
    step(1);
    chk("bubble", {15'd0, valid_o, PC_o, Instr_o}, {15'd0, 1'b0, 16'h0008, 16'h0000});

    // Redirect while a request at 8 is outstanding.
    rst_n = 1'b0;
    step(2);
    imem_ready_i = 1'b1;
    rst_n = 1'b1;
    push(16'h0000, 16'h1000); push(16'h0002, 16'h1002);
    push(16'h0004, 16'h1004); push(16'h0006, 16'h1006);
    step(5);
    imem_ready_i = 1'b0;
    step(1);
    branch_taken_i = 1'b1; branch_target_i = 16'h0040;
    #1;
    chk("flush_on",  {31'd0, IF_ID_Flush}, 32'd1);
    chk("rd_valid",  {31'd0, valid_o}, 32'd0);
    chk("rd_addr",   {16'd0, imem_addr_o}, 32'h0000_0008);
    step(1);
    branch_taken_i = 1'b0;
    #1;
    chk("flush_off",  {31'd0, IF_ID_Flush}, 32'd0);
    chk("drain_addr", {16'd0, imem_addr_o}, 32'h0000_0008);
    chk("drain_req",  {31'd0, imem_req_o}, 32'd1);
    step(1);
    chk("drain_addr2", {16'd0, imem_addr_o}, 32'h0000_0008);
    imem_ready_i = 1'b1;
    step(1);
    chk("post_drain_addr",  {16'd0, imem_addr_o}, 32'h0000_0040);
    chk("post_drain_valid", {31'd0, valid_o}, 32'd0);

    // Redirect while stalled with the skid full.
    step(1);
    chk("pre_stall_pc", {15'd0, valid_o, PC_o}, {15'd0, 1'b1, 16'h0040});
    IF_ID_Hold = 1'b1;
    step(1);
    chk("stall2_req", {31'd0, imem_req_o}, 32'd0);
    branch_taken_i = 1'b1; branch_target_i = 16'h0080;
    step(1);
    branch_taken_i = 1'b0; IF_ID_Hold = 1'b0;
    chk("skid_drop_addr",  {16'd0, imem_addr_o}, 32'h0000_0080);
    chk("skid_drop_valid", {31'd0, valid_o}, 32'd0);
    push(16'h0080, 16'h1080);
    step(2);

    // Redirect near the top of the address space: PC wraps to zero.
    branch_taken_i = 1'b1; branch_target_i = 16'hFFFC;
    step(1);
    branch_taken_i = 1'b0;
    chk("wrap_addr", {16'd0, imem_addr_o}, 32'h0000_FFFC);
    push(16'hFFFC, 16'h0FFC); push(16'hFFFE, 16'h0FFE);
    push(16'h0000, 16'h1000); push(16'h0002, 16'h1002);
    step(4);
    imem_ready_i = 1'b0;

    // Asynchronous reset in the middle of a drain.
    step(1);
    branch_taken_i = 1'b1; branch_target_i = 16'h0100;
    step(1);
    branch_taken_i = 1'b0;
    chk("drain3_state", {15'd0, imem_req_o, imem_addr_o}, {15'd0, 1'b1, 16'h0004});
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", {14'd0, valid_o, imem_req_o, PC_o}, 32'h0000_0000);
    chk("async_rst_instr_addr", {Instr_o, imem_addr_o}, 32'h0000_0000);
    step(2);
    imem_ready_i = 1'b1;
    rst_n = 1'b1;
    chk("rel_req", {31'd0, imem_req_o}, 32'd0);
    step(1);
    chk("rel_first_req", {15'd0, imem_req_o, imem_addr_o}, {15'd0, 1'b1, 16'h0000});
    imem_ready_i = 1'b0;
    step(3);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
